// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: byte width and the state
// encoding of the feeder dispatch FSM that sits in front of UART_TX.
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int BYTE_W = 8;

   // Encoding is fixed so the state can be probed on a debug bus.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if
// Byte-push side and UART_TX handshake side of the feeder, bundled together.
//   wr_en/wr_data  : producer pushes one byte per cycle
//   wr_full        : feeder FIFO full, pushes are dropped
//   tx_start       : one-cycle START pulse to UART_TX
//   tx_data        : byte for UART_TX, held for the whole frame
//   tx_busy        : BUSY from UART_TX
// slave  : the feeder itself
// master : the surroundings (producer plus UART_TX)
// ---------------------------------------------------------------------------
interface uart_tx_feeder_if;

   logic                       wr_en;
   logic [uart_pkg::BYTE_W-1:0] wr_data;
   logic                       wr_full;
   logic                       tx_start;
   logic [uart_pkg::BYTE_W-1:0] tx_data;
   logic                       tx_busy;

   modport master (
      output wr_en, wr_data, tx_busy,
      input  wr_full, tx_start, tx_data
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output wr_full, tx_start, tx_data
   );

endinterface

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous circular byte FIFO with an explicit occupancy counter.
//   clk, reset      : clock, synchronous active-high reset
//   wr_en, wr_data  : push request; ignored while full
//   rd_en           : pop request; ignored while empty
//   rd_data         : byte at the read pointer (combinational)
//   level           : bytes stored, 0..2**DEPTH_LOG2
//   full, empty     : occupancy flags derived from level
// Pointers are DEPTH_LOG2 bits and wrap naturally; level carries the extra
// bit that tells full from empty.
// ---------------------------------------------------------------------------
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [BYTE_W-1:0]     wr_data,
   input  logic                  rd_en,
   output logic [BYTE_W-1:0]     rd_data,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [BYTE_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  push;
   logic                  pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         // push and pop together leave the count alone
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: only slots behind the write pointer are read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO plus dispatch FSM directly upstream of UART_TX. Producers push
// bytes at clock rate; one START/DATA pair is issued per frame, paced on
// UART_TX BUSY so nothing is dropped or issued while a frame is in flight.
//   clk, reset  : system clock (shared with UART_TX), sync active-high reset
//   bus         : push side and UART_TX handshake (slave modport)
//   level       : bytes queued, 0..2**DEPTH_LOG2
//   overflow    : sticky, a push arrived while full
//   tx_err      : sticky, BUSY never rose within BUSY_TMO cycles of START
//   idle        : FIFO empty and FSM in IDLE
// ---------------------------------------------------------------------------
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int BUSY_TMO   = 7
) (
   input  logic                clk,
   input  logic                reset,
   uart_tx_feeder_if.slave     bus,
   output logic [DEPTH_LOG2:0] level,
   output logic                overflow,
   output logic                tx_err,
   output logic                idle
);

   localparam int TMR_W = $clog2(BUSY_TMO + 1);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   // Timer counts WAIT_HI cycles; the error fires on the cycle whose
   // increment would land on BUSY_TMO-1, i.e. BUSY_TMO cycles after the
   // START pulse first became visible.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TMO - 2);

   feeder_state_t     state;
   feeder_state_t     state_nx;
   logic [TMR_W-1:0]  timer;
   logic [BYTE_W-1:0] tx_data_q;

   logic              fifo_pop;
   logic [BYTE_W-1:0] fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic              timer_inc;
   logic              err_set;

   uart_byte_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.wr_en),
      .wr_data (bus.wr_data),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .level   (level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      fifo_pop  = 1'b0;
      timer_inc = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            // BUSY already high here means someone else started a frame;
            // hold off until the line is free.
            if (!fifo_empty && !bus.tx_busy) begin
               fifo_pop = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            state_nx = WAIT_HI;
         end
         WAIT_HI: begin
            if (bus.tx_busy) begin
               state_nx = WAIT_LO;
            end else if (timer == TMR_LAST) begin
               // byte is abandoned; it left the FIFO and stays gone
               err_set  = 1'b1;
               state_nx = IDLE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!bus.tx_busy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         timer <= '0;
      end else if (state == START) begin
         timer <= '0;
      end else if (timer_inc) begin
         timer <= timer + TMR_ONE;
      end
   end

   // Registered so UART_TX sees a byte that holds still for the whole frame
   // regardless of FIFO traffic.
   always_ff @(posedge clk) begin
      if (reset)         tx_data_q <= '0;
      else if (fifo_pop) tx_data_q <= fifo_rd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         if (bus.wr_en && fifo_full) overflow <= 1'b1;
         if (err_set)                tx_err   <= 1'b1;
      end
   end

   assign bus.tx_start = (state == START);
   assign bus.tx_data  = tx_data_q;
   assign bus.wr_full  = fifo_full;
   assign idle         = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
module tb_uart_tx_feeder;
   import uart_pkg::*;

   localparam int DEPTH_LOG2 = 4;
   localparam int BUSY_TMO   = 7;
   localparam int BAUD       = 8;

   logic                clk = 1'b0;
   logic                reset;
   logic [DEPTH_LOG2:0] level;
   logic                overflow, tx_err, idle;

   uart_tx_feeder_if bus();

   uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_TMO(BUSY_TMO)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .level    (level),
      .overflow (overflow),
      .tx_err   (tx_err),
      .idle     (idle)
   );

   always #5 clk = ~clk;

   // ---------------- UART_TX stand-in (8 clocks per bit) ----------------
   logic       uart_en, ext_busy;
   logic       u_busy = 1'b0, tx_line = 1'b1;
   logic [9:0] u_frame;
   logic [7:0] u_byte;
   int         u_bit, u_cnt;

   assign bus.tx_busy = ext_busy | (uart_en & u_busy);

   always @(posedge clk) begin
      if (reset) begin
         u_busy <= 1'b0; tx_line <= 1'b1; u_bit <= 0; u_cnt <= 0;
      end else if (!u_busy) begin
         if (uart_en && bus.tx_start) begin
            u_frame <= {1'b1, bus.tx_data, 1'b0};
            u_byte  <= bus.tx_data;
            u_busy  <= 1'b1; u_bit <= 0; u_cnt <= 0; tx_line <= 1'b0;
         end
      end else if (u_cnt == BAUD-1) begin
         u_cnt <= 0;
         if (u_bit == 9) begin
            u_busy <= 1'b0; tx_line <= 1'b1;
         end else begin
            u_bit <= u_bit + 1; tx_line <= u_frame[u_bit+1];
         end
      end else begin
         u_cnt <= u_cnt + 1;
      end
   end

   // ---------------- line receiver: mid-bit sampling, LSB first ----------------
   int         rx_st = 0, rx_cnt = 0, rx_n = 0, frame_err = 0;
   logic [7:0] rx_sh;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   always @(posedge clk) begin
      if (reset) begin
         rx_st <= 0;
      end else begin
         case (rx_st)
            0: if (tx_line == 1'b0) begin rx_st <= 1; rx_cnt <= 0; end
            1: if (rx_cnt == BAUD/2-1) begin
                  if (tx_line != 1'b0) begin frame_err <= frame_err + 1; rx_st <= 0; end
                  else begin rx_st <= 2; rx_cnt <= 0; rx_n <= 0; end
               end else rx_cnt <= rx_cnt + 1;
            2: if (rx_cnt == BAUD-1) begin
                  rx_sh[rx_n] <= tx_line; rx_cnt <= 0; rx_n <= rx_n + 1;
                  if (rx_n == 7) rx_st <= 3;
               end else rx_cnt <= rx_cnt + 1;
            default: if (rx_cnt == BAUD-1) begin
                  if (tx_line == 1'b1) rx_q.push_back(rx_sh);
                  else frame_err <= frame_err + 1;
                  rx_st <= 0;
               end else rx_cnt <= rx_cnt + 1;
         endcase
      end
   end

   // ---------------- start-pulse protocol monitor ----------------
   int   n_start = 0, n_dbl = 0, n_busy_start = 0, n_unstable = 0;
   logic start_d = 1'b0;

   always @(posedge clk) begin
      start_d <= bus.tx_start;
      if (!reset) begin
         if (bus.tx_start) begin
            n_start <= n_start + 1;
            if (start_d)     n_dbl        <= n_dbl + 1;
            if (bus.tx_busy) n_busy_start <= n_busy_start + 1;
         end
         if (u_busy && bus.tx_data != u_byte) n_unstable <= n_unstable + 1;
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // called on a negedge; one push per call, takes one cycle
   task automatic push(input logic [7:0] b, input bit accepted);
      bus.wr_en = 1'b1; bus.wr_data = b;
      if (accepted) exp_q.push_back(b);
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // wait for everything to go quiet, then compare the received stream
   task automatic drain(input string tag, input int budget);
      int t = 0;
      while (!(idle && !bus.tx_busy && rx_st == 0) && t < budget) begin
         @(negedge clk); t++;
      end
      chk({tag, "_drain_in_time"}, t < budget, 1);
      chk({tag, "_rx_count"}, rx_q.size(), exp_q.size());
      while (rx_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_rx_byte"}, rx_q.pop_front(), exp_q.pop_front());
      rx_q.delete(); exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, t, n;
      logic [7:0] a, b;
      reset = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; uart_en = 1'b1; ext_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_idle", idle, 1);
      chk("rst_start", bus.tx_start, 0);
      chk("rst_full", bus.wr_full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_data", bus.tx_data, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: single byte, latency and framing
      s0 = n_start;
      push(8'hA5, 1);
      chk("t1_start_k", bus.tx_start, 0);
      chk("t1_level", level, 1);
      @(negedge clk);
      chk("t1_start_k1", bus.tx_start, 1);
      chk("t1_tx_data", bus.tx_data, 8'hA5);
      @(negedge clk);
      chk("t1_pulse_end", bus.tx_start, 0);
      drain("t1", 300);
      chk("t1_nstart", n_start - s0, 1);
      chk("t1_idle", idle, 1);

      // 2/3: fill behind an externally busy link, then overflow
      ext_busy = 1'b1;
      @(negedge clk);
      s0 = n_start;
      for (int i = 0; i < 16; i++) push(8'(i), 1);
      chk("t2_full", bus.wr_full, 1);
      chk("t2_level", level, 16);
      chk("t2_no_start", n_start - s0, 0);
      push(8'hEE, 0);
      chk("t3_ovf", overflow, 1);
      chk("t3_level", level, 16);
      ext_busy = 1'b0;
      drain("t2", 3000);
      chk("t2_nstart", n_start - s0, 16);
      chk("t3_ovf_sticky", overflow, 1);
      chk("t2_not_full", bus.wr_full, 0);

      // 5: push on the same cycle the FSM pops, pointers wrap past 15
      for (int i = 0; i < 10; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         push(a, 1);
         chk("t5_level1", level, 1);
         push(b, 1);
         chk("t5_level_same", level, 1);
         drain("t5", 500);
      end

      // 4: UART disconnected -> timeout
      uart_en = 1'b0;
      push(8'h3C, 0);
      t = 0;
      while (!bus.tx_start && t < 10) begin @(negedge clk); t++; end
      chk("t4_start_seen", bus.tx_start, 1);
      t = 0;
      while (!tx_err && t < 20) begin @(negedge clk); t++; end
      chk("t4_err_delay", t, BUSY_TMO);
      chk("t4_level", level, 0);
      chk("t4_idle", idle, 1);
      uart_en = 1'b1;
      drain("t4", 100);
      chk("t4_err_sticky", tx_err, 1);

      // 6: reset mid-frame with 5 bytes queued
      for (int i = 0; i < 6; i++) push(8'($urandom), 1);
      t = 0;
      while (!bus.tx_busy && t < 20) begin @(negedge clk); t++; end
      chk("t6_busy", bus.tx_busy, 1);
      repeat (3) @(negedge clk);
      chk("t6_level5", level, 5);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_level0", level, 0);
      chk("t6_start", bus.tx_start, 0);
      chk("t6_idle", idle, 1);
      chk("t6_ovf", overflow, 0);
      chk("t6_err", tx_err, 0);
      reset = 1'b0;
      exp_q.delete(); rx_q.delete();
      s0 = n_start;
      push(8'h81, 1);
      drain("t6", 300);
      chk("t6_nstart", n_start - s0, 1);

      // 7: random bursts with random gaps, never enough to fill
      n = $urandom_range(6, 14);
      for (int i = 0; i < n; i++) begin
         push(8'($urandom), 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain("t7", 3000);
      chk("t7_ovf", overflow, 0);

      chk("frame_err", frame_err, 0);
      chk("start_double", n_dbl, 0);
      chk("start_while_busy", n_busy_start, 0);
      chk("tx_data_stable", n_unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
